apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
- Parametrised APB4 completer fronting a word-organised register memory.
- Adds byte strobes, configurable wait-state generation (none / fixed / pseudo-random LFSR) and PSLVERR on out-of-range addresses.
- Accepts an abort when the requester drops psel mid-wait.
- Next-generation memory-mapped test target for APB requesters in the day-series designs.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8, at least 16.
- ADDR_W, 10, paddr_i width in bits; byte address.
- DEPTH, 16, number of DATA_W words; must be at most 2^(ADDR_W-LSB), where LSB = clog2(DATA_W/8).
- WAIT_MODE, 2, wait-state source: 0 = none, 1 = fixed WAIT_CYCLES, 2 = 4-bit LFSR.
- WAIT_CYCLES, 3, wait count D used when WAIT_MODE = 1; range 0..15.
- LFSR_SEED, 4'hE, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- paddr_i  in  ADDR_W  byte address
- pwrite_i  in  1  1 = write, 0 = read
- pwdata_i  in  DATA_W  write data
- pstrb_i  in  DATA_W/8  write byte-lane strobes
- prdata_o  out  DATA_W  read data
- pready_o  out  1  transfer complete
- pslverr_o  out  1  transfer error, valid only with pready_o

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; clock is clk, rising edge.
- Reset values:
  - state = IDLE
  - pready_o = 0, pslverr_o = 0, prdata_o = 0
  - LFSR = LFSR_SEED
  - Memory contents are not reset and are undefined until written.
- LFSR:
  - Free-running every cycle out of reset: next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
  - Period is 15; the value 0 never occurs.
  - Sequence from E: E, C, 8, 1, 2, 4, 9, 3, 6, D, A, 5, B, 7, F.
- Word index: idx = paddr_i[ADDR_W-1:LSB]. paddr_i[LSB-1:0] is ignored, so misaligned addresses are truncated. The address is out of range when idx >= DEPTH.
- States:
  - IDLE: on psel_i & penable_i, latch paddr, pwrite, pwdata and pstrb. Go to ACCESS if WAIT_MODE = 0; otherwise go to WAIT and load cnt with D. D is WAIT_CYCLES (mode 1) or the current LFSR value (mode 2).
  - WAIT: if psel_i = 0, abort: go to IDLE with no memory effect and no pready_o. Else if cnt = 0, go to ACCESS. Else decrement cnt.
  - ACCESS: pready_o = 1 for exactly one cycle, then go to IDLE unconditionally.
- Latency (request seen in IDLE at cycle T):
  - Mode 0: pready_o at T+1.
  - Modes 1 and 2: pready_o at T+D+2.
- In the ACCESS cycle:
  - In-range write: for each lane b with latched pstrb[b] = 1, mem[idx][8b+7:8b] <= latched pwdata lane, committed at the end of ACCESS. Lanes with strobe 0 are unchanged.
  - In-range read: prdata_o = mem[idx]; pstrb is ignored.
  - Out of range: pslverr_o = 1, no write, prdata_o = 0.
- Outside ACCESS, prdata_o = 0 and pslverr_o = 0.
- The latched request is used at ACCESS. Changes on the bus after acceptance are ignored.
- Back-to-back transfers: the earliest acceptance of a new request is the IDLE cycle after ACCESS, so throughput is at most one transfer per 2 cycles in mode 0.
- penable_i without psel_i is ignored. In IDLE, psel_i alone (setup phase) causes no state change.
- Reset mid-operation: return immediately to IDLE; the pending transfer is lost with no write; the LFSR is reseeded; memory is retained.

Test Plan:
- Mode 0, DATA_W 32: write 0xDEADBEEF to 0x008 with pstrb 0xF, then read 0x008 -> pready_o at T+1 each; read returns 0xDEADBEEF; pslverr_o = 0.
- Mode 0: write 0x11223344 to 0x004 with pstrb 0xF, then write 0xAABBCCDD with pstrb 0x5, then read -> 0x11BB33DD.
- Mode 1, WAIT_CYCLES 3: write accepted at T -> pready_o high only at T+5, for 1 cycle; psel_i/penable_i held throughout.
- Mode 2: request in the first cycle after reset deassertion (LFSR = E) -> pready_o at T+16; a second request accepted when LFSR = 1 -> pready_o 3 cycles after its acceptance.
- DEPTH 16: read 0x040 (idx 16) -> pready_o with pslverr_o = 1, prdata_o = 0; write to 0x040 leaves mem[0] unchanged (read 0x000 confirms).
- Mode 1: drop psel_i during WAIT -> no pready_o, memory unchanged; assert reset during WAIT of a write -> pready_o stays 0, target word retains its old value.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a word-organised register memory with byte strobes,
// configurable wait-state insertion (none / fixed / LFSR) and PSLVERR on out-of-range words.
module apb_mem_slave #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_MODE   = 2,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [3:0]  LFSR_SEED   = 4'hE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - LSB;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          lfsr_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                accept;
  logic                in_range;
  logic                access;
  logic [MEM_AW-1:0]   mem_idx;
  logic [3:0]          wait_load;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Byte-offset bits are deliberately dropped: misaligned addresses truncate.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^paddr_i[LSB-1:0];

  assign wait_load = (WAIT_MODE == 1) ? 4'(WAIT_CYCLES) : lfsr_q;
  assign in_range  = ({1'b0, idx_q} < DEPTH_L);
  assign access    = (state_q == StAccess);
  assign mem_idx   = idx_q[MEM_AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (psel_i && penable_i) begin
          accept = 1'b1;
          if (WAIT_MODE == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = wait_load;
          end
        end
      end
      StWait: begin
        // Requester dropping psel mid-wait aborts the transfer silently.
        if (!psel_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= paddr_i[ADDR_W-1:LSB];
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= pstrb_i;
      end
    end
  end

  // Memory is intentionally outside the reset domain so it survives a reset.
  always_ff @(posedge clk) begin
    if (access && write_q && in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    pready_o  = access;
    pslverr_o = access && !in_range;
    prdata_o  = '0;
    if (access && !write_q && in_range) prdata_o = mem[mem_idx];
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three completers (no wait, fixed wait, LFSR wait) driven with
// directed and random APB transfers against an array/sequence-table reference model.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [9:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] mm [3][16];
  logic [3:0]  seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                            4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

  always #5 clk = ~clk;

  // Cycles since reset release; the LFSR value of a cycle is seq[cyc % 15].
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  apb_mem_slave #(.WAIT_MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable[0]), .paddr_i(paddr[0]),
    .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]), .prdata_o(prdata[0]),
    .pready_o(pready[0]), .pslverr_o(pslverr[0]));

  apb_mem_slave #(.WAIT_MODE(1), .WAIT_CYCLES(3)) u_m1 (
    .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable[1]), .paddr_i(paddr[1]),
    .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]), .prdata_o(prdata[1]),
    .pready_o(pready[1]), .pslverr_o(pslverr[1]));

  apb_mem_slave #(.WAIT_MODE(2), .LFSR_SEED(4'hE)) u_m2 (
    .clk(clk), .reset(reset), .psel_i(psel[2]), .penable_i(penable[2]), .paddr_i(paddr[2]),
    .pwrite_i(pwrite[2]), .pwdata_i(pwdata[2]), .pstrb_i(pstrb[2]), .prdata_o(prdata[2]),
    .pready_o(pready[2]), .pslverr_o(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance m; pre = access phase already on the bus.
  task automatic xfer(input int m, input bit wr, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int target, input bit pre, input string tag,
                      output logic [31:0] rd);
    int lat;
    int expl;
    int idx;
    bit got;
    idx = int'(a[9:2]);
    rd  = 'x;
    if (!pre) begin
      @(posedge clk); #1;
      if (target >= 0) begin
        while (int'(seq[(cyc + 1) % 15]) != target) begin
          @(posedge clk); #1;
        end
      end
      psel[m] = 1'b1; penable[m] = 1'b0; pwrite[m] = wr;
      paddr[m] = a; pwdata[m] = d; pstrb[m] = s;
      @(posedge clk); #1;
      penable[m] = 1'b1;
    end
    expl = (m == 0) ? 1 : (m == 1) ? 5 : int'(seq[cyc % 15]) + 2;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (pready[m]) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
        if (lat == 1) begin
          // Bus noise after acceptance must not reach the completed transfer.
          paddr[m] = 10'($urandom); pwdata[m] = $urandom;
          pstrb[m] = 4'($urandom); pwrite[m] = ~pwrite[m];
        end
      end
    end
    check({tag, "_latency"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(expl));
    if (got) begin
      rd = prdata[m];
      check({tag, "_pslverr"}, 32'(pslverr[m]), (idx >= 16) ? 32'd1 : 32'd0);
      if (idx >= 16)      check({tag, "_oor_rdata"}, prdata[m], 32'd0);
      else if (!wr)       check({tag, "_rdata"}, prdata[m], mm[m][idx]);
    end
    if (wr && idx < 16) begin
      for (int b = 0; b < 4; b++) if (s[b]) mm[m][idx][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    psel[m] = 1'b0; penable[m] = 1'b0;
    @(negedge clk);
    check({tag, "_ready_one_cycle"}, 32'(pready[m]), 32'd0);
  endtask

  // Start a mode-1 write, let it sit two cycles in WAIT, then abort or reset.
  task automatic interrupted_write(input bit use_reset, input logic [9:0] a, input string tag);
    bit seen;
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = a; pwdata[1] = ~mm[1][a[5:2]]; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= pready[1];
    end
    if (use_reset) reset = 1'b1;
    else begin psel[1] = 1'b0; penable[1] = 1'b0; end
    repeat (2) begin
      @(negedge clk); seen |= pready[1];
      @(posedge clk); #1;
    end
    psel[1] = 1'b0; penable[1] = 1'b0; reset = 1'b0;
    repeat (8) begin
      @(negedge clk); seen |= pready[1];
    end
    check({tag, "_no_ready"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    for (int m = 0; m < 3; m++) begin
      psel[m] = 1'b0; penable[m] = 1'b0; pwrite[m] = 1'b0;
      paddr[m] = '0; pwdata[m] = '0; pstrb[m] = '0;
    end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      check("reset_pready", 32'(pready[m]), 32'd0);
      check("reset_pslverr", 32'(pslverr[m]), 32'd0);
      check("reset_prdata", prdata[m], 32'd0);
    end

    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 16; i++)
        xfer(m, 1'b1, 10'(i * 4), $urandom, 4'hF, -1, 1'b0, "init", rd);

    xfer(0, 1'b1, 10'h008, 32'hDEADBEEF, 4'hF, -1, 1'b0, "m0_wr", rd);
    xfer(0, 1'b0, 10'h008, 32'h0, 4'h0, -1, 1'b0, "m0_rd", rd);
    check("m0_deadbeef", rd, 32'hDEADBEEF);
    xfer(0, 1'b1, 10'h004, 32'h11223344, 4'hF, -1, 1'b0, "m0_wr_full", rd);
    xfer(0, 1'b1, 10'h004, 32'hAABBCCDD, 4'h5, -1, 1'b0, "m0_wr_strb", rd);
    xfer(0, 1'b0, 10'h006, 32'h0, 4'h0, -1, 1'b0, "m0_rd_strb", rd);
    check("strb_merge", rd, 32'h11BB33DD);
    xfer(0, 1'b0, 10'h040, 32'h0, 4'h0, -1, 1'b0, "oor_rd", rd);
    xfer(0, 1'b1, 10'h040, 32'h5A5A5A5A, 4'hF, -1, 1'b0, "oor_wr", rd);
    xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, -1, 1'b0, "oor_mem0", rd);

    xfer(1, 1'b1, 10'h010, 32'hCAFEF00D, 4'hF, -1, 1'b0, "m1_wr", rd);
    xfer(1, 1'b0, 10'h010, 32'h0, 4'h0, -1, 1'b0, "m1_rd", rd);

    // Mode 2: access phase already present when reset releases (LFSR = E).
    @(posedge clk); #1;
    reset = 1'b1;
    psel[2] = 1'b1; penable[2] = 1'b1; pwrite[2] = 1'b1;
    paddr[2] = 10'h014; pwdata[2] = 32'h0BADC0DE; pstrb[2] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(2, 1'b1, 10'h014, 32'h0BADC0DE, 4'hF, -1, 1'b1, "m2_first", rd);
    xfer(2, 1'b0, 10'h014, 32'h0, 4'h0, 1, 1'b0, "m2_lfsr1", rd);
    check("m2_lfsr1_data", rd, 32'h0BADC0DE);

    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 24; i++)
        xfer(m, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 'h4F)), $urandom,
             4'($urandom_range(0, 15)), -1, 1'b0, "rand", rd);

    interrupted_write(1'b0, 10'h020, "abort");
    xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, -1, 1'b0, "abort_rd", rd);
    interrupted_write(1'b1, 10'h024, "reset_wait");
    xfer(1, 1'b0, 10'h024, 32'h0, 4'h0, -1, 1'b0, "reset_wait_rd", rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
